// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM port, pipeline control inputs and the IF/ID register outputs.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/ROM.
interface inst_fetch_if;
   logic        stall_if;
   logic        stall_id;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        flush;
   logic [31:0] flush_pc;
   logic [31:0] inst_addr;
   logic        chip_en;
   logic [31:0] inst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic        misalign_exc;

   modport master (
      input  stall_if, stall_id, branch_flag, branch_target, flush, flush_pc, inst,
      output inst_addr, chip_en, if_id_pc, if_id_inst, if_id_valid, misalign_exc
   );

   modport slave (
      output stall_if, stall_id, branch_flag, branch_target, flush, flush_pc, inst,
      input  inst_addr, chip_en, if_id_pc, if_id_inst, if_id_valid, misalign_exc
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, one-entry pending branch and IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN: align redirect targets and flag misaligned ones.
//
// state | meaning
// IDLE  | out of reset, ROM disabled, PC parked at RESET_PC
// FETCH | fetching, PC advancing
// HOLD  | fetch frozen by stall_if, PC held
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   inst_fetch_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        pend_flag, pend_flag_nxt;
   logic [31:0] pend_tgt, pend_tgt_nxt;
   logic [31:0] br_tgt, fl_tgt;
   logic        running;

   assign running       = (state != IDLE);
   assign bus.inst_addr = pc;
   assign bus.chip_en   = running;

`ifdef FETCH_ALIGN_CHECK_EN
   logic br_take;
   logic misalign_q;

   assign br_tgt  = {bus.branch_target[31:2], 2'b00};
   assign fl_tgt  = {bus.flush_pc[31:2], 2'b00};
   // A branch is accepted either straight into PC or into the pending slot.
   assign br_take = running && bus.branch_flag && (bus.stall_if || !pend_flag);

   always_ff @(posedge clk) begin
      if (rst)
         misalign_q <= 1'b0;
      else if (bus.flush)
         misalign_q <= |bus.flush_pc[1:0];
      else
         misalign_q <= br_take && (|bus.branch_target[1:0]);
   end

   assign bus.misalign_exc = misalign_q;
`else
   assign br_tgt           = bus.branch_target;
   assign fl_tgt           = bus.flush_pc;
   assign bus.misalign_exc = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         pend_flag <= 1'b0;
         pend_tgt  <= 32'h0000_0000;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         pend_flag <= pend_flag_nxt;
         pend_tgt  <= pend_tgt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      pend_flag_nxt = pend_flag;
      pend_tgt_nxt  = pend_tgt;

      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (bus.stall_if) state_nxt = HOLD;
         HOLD:    if (!bus.stall_if) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase

      if (bus.flush) begin
         state_nxt     = FETCH;
         pc_nxt        = fl_tgt;
         pend_flag_nxt = 1'b0;
      end else if (running) begin
         if (bus.stall_if) begin
            // Redirects during a stall are parked; the latest one wins.
            if (bus.branch_flag) begin
               pend_flag_nxt = 1'b1;
               pend_tgt_nxt  = br_tgt;
            end
         end else if (pend_flag) begin
            pc_nxt        = pend_tgt;
            pend_flag_nxt = 1'b0;
         end else if (bus.branch_flag) begin
            pc_nxt = br_tgt;
         end else begin
            pc_nxt = pc + 32'd4;
         end
      end
   end

   // The delay-slot instruction is loaded like any other; no squash path exists.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         bus.if_id_pc    <= 32'h0000_0000;
         bus.if_id_inst  <= 32'h0000_0000;
         bus.if_id_valid <= 1'b0;
      end else if (bus.stall_id) begin
         bus.if_id_pc    <= bus.if_id_pc;
         bus.if_id_inst  <= bus.if_id_inst;
         bus.if_id_valid <= bus.if_id_valid;
      end else if (bus.stall_if || !running) begin
         bus.if_id_pc    <= 32'h0000_0000;
         bus.if_id_inst  <= 32'h0000_0000;
         bus.if_id_valid <= 1'b0;
      end else begin
         bus.if_id_pc    <= pc;
         bus.if_id_inst  <= bus.inst;
         bus.if_id_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by randomized pipeline control,
// all checked against a cycle-level reference of the fetch rules.
module tb_inst_fetch;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   inst_fetch_if bus ();

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign bus.inst = rom_word(bus.inst_addr);

   // reference model: "fetching" becomes true on the first non-reset edge and stays true
   bit          m_fetching;
   logic [31:0] m_pc, m_ptgt, m_vpc, m_vinst;
   bit          m_pend, m_vval, m_mis;

   function automatic logic [31:0] fix_tgt(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
      return t & 32'hFFFF_FFFC;
`else
      return t;
`endif
   endfunction

   function automatic bit odd_tgt(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
      return t[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [31:0] old_pc;
      bit          mis;
      old_pc = m_pc;
      mis    = 1'b0;
      if (rst) begin
         m_fetching = 0; m_pc = 32'h0; m_pend = 0; m_ptgt = 32'h0;
         m_vpc = 32'h0; m_vinst = 32'h0; m_vval = 0; m_mis = 0;
         return;
      end
      if (bus.flush) begin
         m_pc   = fix_tgt(bus.flush_pc);
         mis    = odd_tgt(bus.flush_pc);
         m_pend = 0;
      end else if (m_fetching) begin
         if (bus.stall_if) begin
            if (bus.branch_flag) begin
               m_pend = 1; m_ptgt = fix_tgt(bus.branch_target); mis = odd_tgt(bus.branch_target);
            end
         end else if (m_pend) begin
            m_pc = m_ptgt; m_pend = 0;
         end else if (bus.branch_flag) begin
            m_pc = fix_tgt(bus.branch_target); mis = odd_tgt(bus.branch_target);
         end else begin
            m_pc = old_pc + 32'd4;
         end
      end
      if (bus.flush || (!bus.stall_id && (bus.stall_if || !m_fetching))) begin
         m_vpc = 32'h0; m_vinst = 32'h0; m_vval = 0;
      end else if (!bus.stall_id) begin
         m_vpc = old_pc; m_vinst = rom_word(old_pc); m_vval = 1;
      end
      m_mis      = mis;
      m_fetching = 1;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("inst_addr",    bus.inst_addr,    m_pc);
      chk("chip_en",      {31'b0, bus.chip_en}, {31'b0, m_fetching});
      chk("if_id_pc",     bus.if_id_pc,     m_vpc);
      chk("if_id_inst",   bus.if_id_inst,   m_vinst);
      chk("if_id_valid",  {31'b0, bus.if_id_valid},  {31'b0, m_vval});
      chk("misalign_exc", {31'b0, bus.misalign_exc}, {31'b0, m_mis});
   endtask

   task automatic drive(input bit r, input bit sif, input bit sid, input bit bf,
                        input logic [31:0] bt, input bit fl, input logic [31:0] fp);
      rst = r; bus.stall_if = sif; bus.stall_id = sid; bus.branch_flag = bf;
      bus.branch_target = bt; bus.flush = fl; bus.flush_pc = fp;
   endtask

   initial begin
      drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
      repeat (3) cycle();

      // out of reset: IDLE for one cycle, then sequential fetch
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("idle_chip_en", {31'b0, bus.chip_en}, 32'h0);
      chk("idle_addr", bus.inst_addr, 32'h0);
      cycle();
      chk("first_addr", bus.inst_addr, 32'h0);
      chk("first_valid", {31'b0, bus.if_id_valid}, 32'h0);
      cycle();
      chk("seq_addr4", bus.inst_addr, 32'h4);
      chk("seq_ifpc0", bus.if_id_pc, 32'h0);
      cycle();
      chk("seq_addr8", bus.inst_addr, 32'h8);

      // branch at PC=8: delay slot kept
      drive(0, 0, 0, 1, 32'h100, 0, 32'h0);
      cycle();
      chk("br_addr", bus.inst_addr, 32'h100);
      chk("br_delay_pc", bus.if_id_pc, 32'h8);
      chk("br_delay_valid", {31'b0, bus.if_id_valid}, 32'h1);

      // stall_if at PC=0x20 with a branch parked during the stall
      drive(0, 0, 0, 0, 32'h0, 1, 32'h20);
      cycle();
      chk("fl20_addr", bus.inst_addr, 32'h20);
      drive(0, 1, 0, 1, 32'h200, 0, 32'h0);
      cycle();
      chk("stall_addr", bus.inst_addr, 32'h20);
      chk("stall_bubble", {31'b0, bus.if_id_valid}, 32'h0);
      drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
      repeat (2) cycle();
      chk("stall_addr3", bus.inst_addr, 32'h20);
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
      chk("pend_applied", bus.inst_addr, 32'h200);
      chk("pend_ifpc", bus.if_id_pc, 32'h20);
      cycle();

      // both stalls hold IF/ID; flush overrides everything and drops pending
      drive(0, 1, 1, 1, 32'h300, 0, 32'h0);
      cycle();
      drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
      repeat (2) cycle();
      chk("sid_hold_pc", bus.if_id_pc, 32'h200);
      chk("sid_hold_valid", {31'b0, bus.if_id_valid}, 32'h1);
      drive(0, 1, 1, 1, 32'h400, 1, 32'h180);
      cycle();
      chk("flush_addr", bus.inst_addr, 32'h180);
      chk("flush_bubble", {31'b0, bus.if_id_valid}, 32'h0);
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
      chk("flush_no_pend", bus.inst_addr, 32'h184);

      // PC wrap
      drive(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
      cycle();
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
      chk("wrap_addr", bus.inst_addr, 32'h0);
      chk("wrap_ifpc", bus.if_id_pc, 32'hFFFF_FFFC);

      // misaligned branch target
      drive(0, 0, 0, 1, 32'h103, 0, 32'h0);
      cycle();
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_addr", bus.inst_addr, 32'h100);
      chk("mis_exc", {31'b0, bus.misalign_exc}, 32'h1);
`else
      chk("mis_addr", bus.inst_addr, 32'h103);
      chk("mis_exc", {31'b0, bus.misalign_exc}, 32'h0);
`endif
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
      chk("mis_exc_pulse", {31'b0, bus.misalign_exc}, 32'h0);

      // randomized pipeline control
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] bt, fp;
         bt = $urandom();
         fp = $urandom();
         if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) fp[1:0] = 2'b00;
         drive($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 12, bt,
               $urandom_range(0, 99) < 5, fp);
         if (i % 500 == 0) begin
            // occasional wrap boundary approach
            bus.flush = 1'b1; bus.flush_pc = 32'hFFFF_FFF8;
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_if  input  1  freeze PC; IF produces no new instruction.
REQ-005 stall_id  input  1  freeze IF/ID register (decode stalled).
REQ-006 branch_flag  input  1  redirect request from ID; single-cycle pulse.
REQ-007 branch_target  input  32  redirect address, valid with branch_flag.
REQ-008 flush  input  1  exception/pipeline flush request.
REQ-009 flush_pc  input  32  restart address, valid with flush.
REQ-010 inst_addr  output  32  byte address to instruction ROM (ROM consumes bits [18:2]).
REQ-011 chip_en  output  1  ROM enable.
REQ-012 inst  input  32  combinational ROM read data for inst_addr, same cycle.
REQ-013 if_id_pc  output  32  registered PC of instruction handed to decode.
REQ-014 if_id_inst  output  32  registered instruction handed to decode.
REQ-015 if_id_valid  output  1  if_id_inst is a real fetched instruction (0 = bubble).
REQ-016 misalign_exc  output  1  misaligned redirect target detected (see Configuration).

Function
REQ-017 The block SHALL implement states IDLE, FETCH, HOLD; IDLE->FETCH on first clock with rst low; FETCH->HOLD when stall_if=1; HOLD->FETCH when stall_if=0; any state->FETCH on flush.
REQ-018 In IDLE chip_en SHALL be 0 and inst_addr SHALL equal RESET_PC; in FETCH and HOLD chip_en SHALL be 1.
REQ-019 inst_addr SHALL be the PC register; ROM data is sampled into IF/ID at the same edge that advances the PC (zero-cycle ROM latency, one-cycle IF latency).
REQ-020 PC update priority per edge: flush -> flush_pc; else stall_if -> hold; else pending branch -> pending target; else branch_flag -> branch_target; else PC+4.
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 A branch_flag arriving with stall_if=1 SHALL be latched into a one-entry pending register (flag+target) and applied on the first edge with stall_if=0; a second branch_flag while pending SHALL overwrite the target.
REQ-023 IF/ID update priority: flush -> bubble; else stall_id -> hold all three registers; else stall_if or state IDLE -> bubble; else load {PC, inst, valid=1}.
REQ-024 A bubble SHALL be if_id_pc=0, if_id_inst=32'h0000_0000 (nop), if_id_valid=0.
REQ-025 The instruction fetched in the same cycle as branch_flag (delay slot) SHALL be loaded into IF/ID normally; it SHALL NOT be squashed.
REQ-026 flush SHALL clear the pending branch register and override simultaneous stall_if, stall_id and branch_flag.

Reset
REQ-027 On rst=1 at an edge: state=IDLE, PC=RESET_PC, chip_en=0, pending cleared, if_id_pc=0, if_id_inst=0, if_id_valid=0, misalign_exc=0.
REQ-028 Reset asserted mid-stall or with a pending branch SHALL discard all in-flight state; rst overrides every other input.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN defined: any flush_pc or branch_target accepted into PC/pending with bits[1:0]!=0 SHALL be loaded with bits[1:0] cleared and misalign_exc SHALL pulse 1 for exactly the cycle after acceptance.
REQ-030 Macro undefined: targets loaded unmodified, misalign_exc tied to 0, no check logic synthesized.

Verification
REQ-031 rst 3 cycles then release, RESET_PC=0 -> cycle 1 chip_en=0, then inst_addr 0,4,8,... and if_id_pc lags inst_addr by one cycle with if_id_valid=1.
REQ-032 branch_flag=1, branch_target=32'h100 at PC=8 -> IF/ID gets PC 8 (delay slot), next inst_addr=32'h100.
REQ-033 stall_if=1 for 3 cycles at PC=32'h20, stall_id=0 -> inst_addr holds 32'h20, three bubbles; branch_flag during stall to 32'h200 -> first unstalled edge PC=32'h200.
REQ-034 stall_id=1 with stall_if=1 -> if_id_* unchanged for full stall duration; flush=1, flush_pc=32'h180 with both stalls -> PC=32'h180, bubble, pending cleared.
REQ-035 PC=32'hFFFF_FFFC, no stall -> next inst_addr=32'h0000_0000.
REQ-036 FETCH_ALIGN_CHECK_EN defined, branch_target=32'h103 -> PC=32'h100, misalign_exc=1 one cycle; undefined -> PC=32'h103, misalign_exc=0.
